// File: rtl/lane_deserializer_pkg.sv
// Shared state type, beat-count helper and elaboration-time parameter checks
// for the lane deserializer.
`ifndef LANE_DESER_PKG_SV
`define LANE_DESER_PKG_SV

package lane_deser_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} deser_state_e;

  function automatic int beats_f(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

  function automatic bit is_pow2_f(input int n);
    return (n >= 1) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`define LANE_DESER_CHECK_PARAMS(DW, LN, DEPTH) \
  if (((DW) % (LN)) != 0) begin : g_bad_lanes \
    $error("LANES must divide DATA_WIDTH"); \
  end \
  if (!lane_deser_pkg::is_pow2_f(DEPTH)) begin : g_bad_depth \
    $error("OUT_DEPTH must be a power of 2"); \
  end

`endif

// File: rtl/lane_deserializer_fifo.sv
// Output word buffer: single-clock FIFO with occupancy count.
// The head reads as zero while empty; push and pop may coincide even when full.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_deserializer.sv
// Lane deserializer: assembles DATA_WIDTH-bit words from LANES-bit beats into an output FIFO.
// Define LANE_DESER_PARITY_CHECK_EN to require a trailing even-parity beat after every word.
module lane_deserializer
  import lane_deser_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int LANES       = 1,
  parameter int MSB_FIRST   = 0,
  parameter int OUT_DEPTH   = 2,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [LANES-1:0]      i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output logic                  o_frame_err,
  output logic                  o_parity_err
);

  localparam int BEATS = beats_f(DATA_WIDTH, LANES);
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam int CW    = $clog2(OUT_DEPTH + 1);
  localparam int CW1   = CW + 1;

  `LANE_DESER_CHECK_PARAMS(DATA_WIDTH, LANES, OUT_DEPTH)

  deser_state_e          state;
  deser_state_e          next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         beat_idx;
  logic [IW-1:0]         wr_pos;
  int                    wr_base;
  logic [GW-1:0]         gap_cnt;
  logic                  push_pending;
  logic [CW-1:0]         fifo_count;
  logic                  accept;
  logic                  idle_tick;
  logic                  gap_hit;
  logic                  last_data_beat;
  logic                  load_beat;
  logic                  idx_inc;
  logic                  idx_clr;
  logic                  gap_inc;
  logic                  gap_clr;
  logic                  set_push;
  logic                  abort;
`ifdef LANE_DESER_PARITY_CHECK_EN
  logic                  parity_ok;
  logic                  parity_fail;
`endif

  // A pending push reserves its FIFO slot so back-to-back single-beat words cannot overflow.
  assign o_ready = i_en && !i_rst &&
                   ((CW1'(fifo_count) + CW1'(push_pending)) < CW1'(OUT_DEPTH));

  assign accept         = i_en && i_din_valid && o_ready;
  assign idle_tick      = i_en && !i_din_valid;
  assign gap_hit        = (GAP_TIMEOUT != 0) && idle_tick && (gap_cnt == GW'(GAP_TIMEOUT - 1));
  assign last_data_beat = (beat_idx == IW'(BEATS - 1));
  assign wr_pos         = (MSB_FIRST != 0) ? (IW'(BEATS - 1) - beat_idx) : beat_idx;
  assign wr_base        = LANES * int'(wr_pos);
  assign o_dout_valid   = (fifo_count != '0);
`ifdef LANE_DESER_PARITY_CHECK_EN
  assign parity_ok      = (i_din[0] == ^shreg);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_beat  = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    gap_inc    = 1'b0;
    gap_clr    = 1'b0;
    set_push   = 1'b0;
    abort      = 1'b0;
`ifdef LANE_DESER_PARITY_CHECK_EN
    parity_fail = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          load_beat = 1'b1;
          gap_clr   = 1'b1;
          if (BEATS == 1) begin
`ifdef LANE_DESER_PARITY_CHECK_EN
            next_state = PARITY;
`else
            set_push   = 1'b1;
`endif
          end else begin
            next_state = SHIFT;
            idx_inc    = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          load_beat = 1'b1;
          gap_clr   = 1'b1;
          if (last_data_beat) begin
            idx_clr = 1'b1;
`ifdef LANE_DESER_PARITY_CHECK_EN
            next_state = PARITY;
`else
            next_state = IDLE;
            set_push   = 1'b1;
`endif
          end else begin
            idx_inc = 1'b1;
          end
        end else if (gap_hit) begin
          abort      = 1'b1;
          idx_clr    = 1'b1;
          gap_clr    = 1'b1;
          next_state = IDLE;
        end else if (idle_tick) begin
          gap_inc = 1'b1;
        end
      end
`ifdef LANE_DESER_PARITY_CHECK_EN
      PARITY: begin
        if (accept) begin
          gap_clr    = 1'b1;
          next_state = IDLE;
          if (parity_ok) set_push    = 1'b1;
          else           parity_fail = 1'b1;
        end else if (gap_hit) begin
          abort      = 1'b1;
          gap_clr    = 1'b1;
          next_state = IDLE;
        end else if (idle_tick) begin
          gap_inc = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shreg        <= '0;
      beat_idx     <= '0;
      gap_cnt      <= '0;
      push_pending <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      push_pending <= set_push;
      o_frame_err  <= abort;
      if (load_beat) shreg[wr_base +: LANES] <= i_din;
      if (idx_clr)      beat_idx <= '0;
      else if (idx_inc) beat_idx <= beat_idx + 1'b1;
      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + 1'b1;
    end
  end

`ifdef LANE_DESER_PARITY_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_parity_err <= 1'b0;
    else       o_parity_err <= parity_fail;
  end
`else
  assign o_parity_err = 1'b0;
`endif

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push_pending),
    .push_data(shreg),
    .pop      (i_ready),
    .head     (o_dout),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_lane_deserializer.sv
// Randomized scoreboard bench for lane_deserializer: a LANES=1 LSB-first instance
// and a LANES=4 MSB-first instance, each checked against words queued by the stimulus.
module tb_lane_deserializer;

  localparam int DW    = 24;
  localparam int DEPTH = 2;
  localparam int GAP   = 16;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad   = 0;

  logic          rst;
  logic          en;
  logic [0:0]    din;
  logic          din_valid;
  logic          ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          cons_ready;
  logic          frame_err;
  logic          parity_err;

  logic          en4;
  logic [3:0]    din4;
  logic          din_valid4;
  logic          ready4;
  logic [DW-1:0] dout4;
  logic          dout_valid4;
  logic          cons_ready4 = 1'b1;
  logic          frame_err4;
  logic          parity_err4;

  logic man_rdy;
  logic rand_rdy = 1'b1;
  logic rnd_ready;
  assign cons_ready = rnd_ready ? rand_rdy : man_rdy;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  int frame_cnt_a  = 0;
  int parity_cnt_a = 0;
  int err_cnt_b    = 0;

  lane_deserializer #(
    .DATA_WIDTH(DW), .LANES(1), .MSB_FIRST(0), .OUT_DEPTH(DEPTH), .GAP_TIMEOUT(GAP)
  ) dut_a (
    .i_clk(tb_clk), .i_rst(rst), .i_en(en), .i_din(din), .i_din_valid(din_valid),
    .o_ready(ready), .o_dout(dout), .o_dout_valid(dout_valid), .i_ready(cons_ready),
    .o_frame_err(frame_err), .o_parity_err(parity_err)
  );

  lane_deserializer #(
    .DATA_WIDTH(DW), .LANES(4), .MSB_FIRST(1), .OUT_DEPTH(DEPTH), .GAP_TIMEOUT(GAP)
  ) dut_b (
    .i_clk(tb_clk), .i_rst(rst), .i_en(en4), .i_din(din4), .i_din_valid(din_valid4),
    .o_ready(ready4), .o_dout(dout4), .o_dout_valid(dout_valid4), .i_ready(cons_ready4),
    .o_frame_err(frame_err4), .o_parity_err(parity_err4)
  );

  always @(posedge tb_clk) begin
    if (rnd_ready) begin
      #1 rand_rdy = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards whenever a word leaves either FIFO at the coming edge.
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (frame_err)  frame_cnt_a++;
      if (parity_err) parity_cnt_a++;
      if (frame_err4 || parity_err4) err_cnt_b++;
      if (dout_valid && cons_ready) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL pop_a: got word 0x%0h expected no word (scoreboard empty)", dout);
        end else begin
          checkOutput("pop_a", dout, exp_a.pop_front());
        end
      end
      if (dout_valid4 && cons_ready4) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL pop_b: got word 0x%0h expected no word (scoreboard empty)", dout4);
        end else begin
          checkOutput("pop_b", dout4, exp_b.pop_front());
        end
      end
      if (dut_a.push_pending) begin
        total++;
        if (int'(dut_a.fifo_count) == DEPTH && !(dout_valid && cons_ready)) begin
          bad++;
          $display("[TB] FAIL overflow_a: got push into full FIFO expected none");
        end
      end
    end
  end

  task automatic applyStimulus(input bit sel, input logic [3:0] beat);
    int waited = 0;
    if (sel) begin din4 = beat; din_valid4 = 1'b1; end
    else     begin din = beat[0]; din_valid = 1'b1; end
    while (1) begin
      @(negedge tb_clk);
      if (sel ? ready4 : ready) break;
      waited++;
      if (waited >= 200) begin
        total++; bad++;
        $display("[TB] FAIL accept_timeout: got o_ready=0 for %0d cycles expected 1", waited);
        break;
      end
    end
    @(posedge tb_clk); #1;
    din_valid  = 1'b0;
    din_valid4 = 1'b0;
  endtask

  task automatic idle_gap(input bit sel);
    int n = $urandom_range(0, 3);
    repeat (n) begin
      if (sel) en4 = ($urandom_range(0, 3) != 0);
      else     en  = ($urandom_range(0, 3) != 0);
      @(posedge tb_clk); #1;
    end
    en  = 1'b1;
    en4 = 1'b1;
  endtask

  task automatic send_word(input bit sel, input logic [DW-1:0] w, input bit bad_par, input bit gaps);
    int nb = sel ? DW / 4 : DW;
    for (int k = 0; k < nb; k++) begin
      logic [3:0] beat;
      if (gaps) idle_gap(sel);
      if (sel) beat = 4'((w >> (DW - 4 * (k + 1))) & 24'hF);
      else     beat = {3'b000, w[k]};
      applyStimulus(sel, beat);
    end
`ifdef LANE_DESER_PARITY_CHECK_EN
    if (gaps) idle_gap(sel);
    applyStimulus(sel, {3'b000, (^w) ^ bad_par});
`endif
    if (!bad_par) begin
      if (sel) exp_b.push_back(w);
      else     exp_a.push_back(w);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
      @(posedge tb_clk);
      n++;
    end
    #1;
    checkOutput("drain_a", exp_a.size(), 0);
    checkOutput("drain_b", exp_b.size(), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din = '0; din_valid = 1'b0;
    en4 = 1'b1; din4 = '0; din_valid4 = 1'b0;
    man_rdy = 1'b1; rnd_ready = 1'b0;
    repeat (2) @(posedge tb_clk);
    #1;
    checkOutput("rst_ready",      ready, 0);
    checkOutput("rst_dout_valid", dout_valid, 0);
    checkOutput("rst_dout",       dout, 0);
    checkOutput("rst_frame_err",  frame_err, 0);
    checkOutput("rst_parity_err", parity_err, 0);
    rst = 1'b0;

    // LSB-first single-lane word with latency check
    send_word(0, 24'hA5C3F0, 1'b0, 1'b0);
    checkOutput("lat1_valid_early", dout_valid, 0);
    @(posedge tb_clk); #1;
    checkOutput("lat1_valid", dout_valid, 1);
    checkOutput("lat1_dout",  dout, 24'hA5C3F0);
    wait_drain();

    // MSB-first four-lane word with latency check
    send_word(1, 24'hA5C3F0, 1'b0, 1'b0);
    checkOutput("lat4_valid_early", dout_valid4, 0);
    @(posedge tb_clk); #1;
    checkOutput("lat4_valid", dout_valid4, 1);
    checkOutput("lat4_dout",  dout4, 24'hA5C3F0);
    wait_drain();

    // Back-pressure: consumer stalled, FIFO fills after two words
    man_rdy = 1'b0;
    send_word(0, 24'h000001, 1'b0, 1'b0);
    send_word(0, 24'h000002, 1'b0, 1'b0);
    checkOutput("full_ready", ready, 0);
    @(posedge tb_clk); #1;
    checkOutput("full_ready_hold", ready, 0);
    checkOutput("full_head", dout, 24'h000001);
    fork
      send_word(0, 24'h000003, 1'b0, 1'b0);
      begin
        repeat (5) @(posedge tb_clk);
        #1 man_rdy = 1'b1;
      end
    join
    wait_drain();

    // Gap timeout aborts a partial word
    for (int k = 0; k < 10; k++) applyStimulus(0, 4'($urandom_range(0, 1)));
    repeat (15) @(posedge tb_clk);
    @(negedge tb_clk);
    checkOutput("gap_no_err_early", frame_err, 0);
    @(posedge tb_clk);
    @(negedge tb_clk);
    checkOutput("gap_frame_err", frame_err, 1);
    @(negedge tb_clk);
    checkOutput("gap_frame_err_pulse", frame_err, 0);
    checkOutput("gap_no_push", dout_valid, 0);
    @(posedge tb_clk); #1;
    send_word(0, 24'h123456, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-word discards the partial word
    for (int k = 0; k < 12; k++) applyStimulus(0, 4'b0001);
    rst = 1'b1;
    @(posedge tb_clk); #1;
    checkOutput("mid_rst_ready",      ready, 0);
    checkOutput("mid_rst_dout_valid", dout_valid, 0);
    checkOutput("mid_rst_dout",       dout, 0);
    checkOutput("mid_rst_frame_err",  frame_err, 0);
    checkOutput("mid_rst_parity_err", parity_err, 0);
    rst = 1'b0;
    send_word(0, 24'h7FFFFF, 1'b0, 1'b0);
    wait_drain();

`ifdef LANE_DESER_PARITY_CHECK_EN
    send_word(0, 24'h000001, 1'b0, 1'b0);
    wait_drain();
    send_word(0, 24'h000001, 1'b1, 1'b0);
    checkOutput("par_err", parity_err, 1);
    @(posedge tb_clk); #1;
    checkOutput("par_err_pulse", parity_err, 0);
    checkOutput("par_no_push", dout_valid, 0);
`endif

    // Randomized traffic with enable drops, gaps and consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) send_word(0, DW'($urandom()), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send_word(1, DW'($urandom()), 1'b0, 1'b1);
    rnd_ready = 1'b0;
    man_rdy   = 1'b1;
    wait_drain();

    checkOutput("frame_err_count", frame_cnt_a, 1);
`ifdef LANE_DESER_PARITY_CHECK_EN
    checkOutput("parity_err_count", parity_cnt_a, 1);
`else
    checkOutput("parity_err_count", parity_cnt_a, 0);
`endif
    checkOutput("b_err_count", err_cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("[TB] FAIL watchdog: got time limit reached expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
